// File: rtl/ldm_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
// Holds the FSM state type, word/register sizing and a list popcount helper.
package ldm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } ldm_state_t;

    localparam int WORD_BYTES = 4;
    localparam int NREGS      = 16;
    localparam int REG_IDX_W  = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lowest_set16.sv
// Priority encoder: index of the lowest set bit of a 16-bit register list,
// with o_valid low when the list is empty.
module lowest_set16
    import ldm_pkg::*;
(
    input  logic [15:0]          i_list,
    output logic [REG_IDX_W-1:0] o_idx,
    output logic                 o_valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx   = REG_IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Multi-cycle LDM/STM sequencer: walks a register list lowest-first, moving one
// word per memory acknowledge, then optionally writes the final address back.
module ldm_stm_seq #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_load,
    input  logic [NREGS-1:0]         reg_list,
    input  logic [DATA_W-1:0]        base_addr,
    input  logic [$clog2(NREGS)-1:0] base_reg,
    input  logic                     up,
    input  logic                     pre,
    input  logic                     writeback,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREGS)-1:0] rf_read_addr,
    input  logic [DATA_W-1:0]        rf_read_data,
    output logic                     rf_wr_en,
    output logic [$clog2(NREGS)-1:0] rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata
);
    import ldm_pkg::*;

    localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

    ldm_state_t r_state;
    ldm_state_t w_next;

    logic [NREGS-1:0]     r_list;
    logic [DATA_W-1:0]    r_base;
    logic [DATA_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_final;
    logic [REG_IDX_W-1:0] r_base_reg;
    logic                 r_is_load;
    logic                 r_up;
    logic                 r_pre;
    logic                 r_wb;
    logic                 r_skip_wb;

    logic [REG_IDX_W-1:0] w_cur_idx;
    logic                 w_list_valid;
    logic [NREGS-1:0]     w_cur_bit;
    logic [NREGS-1:0]     w_list_next;
    logic                 w_last;
    logic [4:0]           w_count;
    logic [DATA_W-1:0]    w_span;
    logic [DATA_W-1:0]    w_start_addr;

    lowest_set16 u_lowest (
        .i_list  (r_list),
        .o_idx   (w_cur_idx),
        .o_valid (w_list_valid)
    );

    assign w_cur_bit   = NREGS'(1) << w_cur_idx;
    assign w_list_next = r_list & ~w_cur_bit;
    assign w_last      = (w_list_next == '0);
    assign w_count     = popcount16(r_list);
    assign w_span      = DATA_W'({w_count, 2'b00});

    // Lowest address of the block; registers always ascend from here.
    assign w_start_addr = r_up ? (r_pre ? r_base + STEP : r_base)
                               : (r_pre ? r_base - w_span : r_base - w_span + STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != S_IDLE);
        done          = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_read_addr  = '0;
        rf_wr_en      = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!w_list_valid) begin
                    w_next = r_wb ? S_WB : S_DONE;
                end else begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                mem_we   = !r_is_load;
                if (r_is_load) begin
                    rf_wr_en      = mem_ack;
                    rf_write_addr = w_cur_idx;
                    rf_write_data = mem_rdata;
                end else begin
                    rf_read_addr = w_cur_idx;
                    mem_wdata    = rf_read_data;
                end
                if (mem_ack && w_last) begin
                    w_next = r_wb ? S_WB : S_DONE;
                end
            end
            S_WB: begin
                // A loaded base register keeps its loaded value.
                rf_wr_en      = !r_skip_wb;
                rf_write_addr = r_base_reg;
                rf_write_data = r_final;
                w_next        = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_list     <= '0;
            r_base     <= '0;
            r_addr     <= '0;
            r_final    <= '0;
            r_base_reg <= '0;
            r_is_load  <= 1'b0;
            r_up       <= 1'b0;
            r_pre      <= 1'b0;
            r_wb       <= 1'b0;
            r_skip_wb  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_list     <= reg_list;
                        r_base     <= base_addr;
                        r_base_reg <= base_reg;
                        r_is_load  <= is_load;
                        r_up       <= up;
                        r_pre      <= pre;
                        r_wb       <= writeback;
                        r_skip_wb  <= is_load & reg_list[base_reg];
                    end
                end
                S_SETUP: begin
                    r_addr  <= w_start_addr;
                    r_final <= r_up ? r_base + w_span : r_base - w_span;
                end
                S_XFER: begin
                    if (mem_ack) begin
                        r_list <= w_list_next;
                        r_addr <= r_addr + STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed and random LDM/STM transfers
// against a list-walking reference model, with a wait-state memory responder.
module tb_ldm_stm_seq;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } tx_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        is_load   = 1'b0;
    logic        up        = 1'b0;
    logic        pre       = 1'b0;
    logic        writeback = 1'b0;
    logic [15:0] reg_list  = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  base_reg  = '0;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        busy, done, rf_wr_en, mem_req, mem_we;
    logic [3:0]  rf_read_addr, rf_write_addr;
    logic [31:0] rf_read_data, rf_write_data, mem_addr, mem_wdata;

    logic [31:0] rf  [16];
    logic [31:0] mem [256];

    int  vectors     = 0;
    int  miscompares = 0;
    int  waitCfg     = 0;
    bit  strayAck    = 1'b0;

    tx_t txQ[$];
    wr_t wrQ[$];
    int  stabErr   = 0;
    int  reqCycles = 0;

    ldm_stm_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .is_load       (is_load),
        .reg_list      (reg_list),
        .base_addr     (base_addr),
        .base_reg      (base_reg),
        .up            (up),
        .pre           (pre),
        .writeback     (writeback),
        .busy          (busy),
        .done          (done),
        .rf_read_addr  (rf_read_addr),
        .rf_read_data  (rf_read_data),
        .rf_wr_en      (rf_wr_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];

    // Memory responder: acknowledges each new request after waitCfg idle cycles.
    int waitLeft = 0;
    bit inReq    = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            inReq   = 1'b0;
        end else if (mem_req) begin
            if (!inReq) begin
                inReq    = 1'b1;
                waitLeft = waitCfg;
            end
            if (waitLeft == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? $urandom : mem[mem_addr[9:2]];
                inReq     = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                waitLeft--;
            end
        end else begin
            inReq     = 1'b0;
            mem_ack   = strayAck ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Observer: logs completed memory beats and register writes mid-cycle.
    bit          pending   = 1'b0;
    logic [31:0] prevAddr  = '0;
    logic [31:0] prevWdata = '0;
    logic        prevWe    = 1'b0;
    always @(negedge clk) begin
        tx_t t;
        wr_t w;
        if (mem_req) begin
            if (pending && (mem_addr !== prevAddr || mem_we !== prevWe || mem_wdata !== prevWdata)) begin
                stabErr++;
            end
            if (mem_ack) begin
                t.addr = mem_addr;
                t.data = mem_we ? mem_wdata : mem_rdata;
                t.we   = mem_we;
                txQ.push_back(t);
                pending = 1'b0;
            end else begin
                pending   = 1'b1;
                prevAddr  = mem_addr;
                prevWe    = mem_we;
                prevWdata = mem_wdata;
            end
            reqCycles++;
        end else begin
            pending = 1'b0;
        end
        if (rf_wr_en) begin
            w.idx  = rf_write_addr;
            w.data = rf_write_data;
            wrQ.push_back(w);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one transfer and checks beats, writes and timing against the model.
    task automatic applyStimulus(input bit ld, input logic [31:0] base, input logic [3:0] breg,
                                 input logic [15:0] list, input bit u, input bit p,
                                 input bit wb, input int w);
        tx_t         expTx[$];
        wr_t         expWr[$];
        tx_t         e;
        wr_t         ew;
        int          n, cyc, expCyc, tx0, wr0, st0, rq0, cnt;
        logic [31:0] lowest, fin, a;

        rf[breg] = base;
        n      = $countones(list);
        fin    = u ? base + 32'(4 * n) : base - 32'(4 * n);
        lowest = u ? (p ? base + 32'd4 : base)
                   : (p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
        a = lowest;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                e.addr = a;
                e.we   = !ld;
                e.data = ld ? mem[a[9:2]] : rf[i];
                expTx.push_back(e);
                if (ld) begin
                    ew.idx  = 4'(i);
                    ew.data = mem[a[9:2]];
                    expWr.push_back(ew);
                end
                a = a + 32'd4;
            end
        end
        if (wb && !(ld && list[breg])) begin
            ew.idx  = breg;
            ew.data = fin;
            expWr.push_back(ew);
        end
        expCyc = 2 + n * (w + 1) + (wb ? 1 : 0);

        tx0 = txQ.size();
        wr0 = wrQ.size();
        st0 = stabErr;
        rq0 = reqCycles;
        waitCfg = w;

        @(negedge clk);
        is_load   = ld;
        base_addr = base;
        base_reg  = breg;
        reg_list  = list;
        up        = u;
        pre       = p;
        writeback = wb;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        is_load   = 1'($urandom_range(0, 1));
        base_addr = $urandom;
        base_reg  = 4'($urandom_range(0, 15));
        reg_list  = 16'($urandom);
        up        = 1'($urandom_range(0, 1));
        pre       = 1'($urandom_range(0, 1));
        writeback = 1'($urandom_range(0, 1));
        checkOutput("busy_setup", 32'(busy), 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("done_cycle", 32'(cyc), 32'(expCyc));
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        checkOutput("tx_count", 32'(txQ.size() - tx0), 32'(expTx.size()));
        cnt = (txQ.size() - tx0 < expTx.size()) ? txQ.size() - tx0 : expTx.size();
        for (int k = 0; k < cnt; k++) begin
            checkOutput("tx_addr", txQ[tx0 + k].addr, expTx[k].addr);
            checkOutput("tx_data", txQ[tx0 + k].data, expTx[k].data);
            checkOutput("tx_we", 32'(txQ[tx0 + k].we), 32'(expTx[k].we));
        end
        checkOutput("wr_count", 32'(wrQ.size() - wr0), 32'(expWr.size()));
        cnt = (wrQ.size() - wr0 < expWr.size()) ? wrQ.size() - wr0 : expWr.size();
        for (int k = 0; k < cnt; k++) begin
            checkOutput("wr_idx", 32'(wrQ[wr0 + k].idx), 32'(expWr[k].idx));
            checkOutput("wr_data", wrQ[wr0 + k].data, expWr[k].data);
        end
        checkOutput("hold_stable", 32'(stabErr - st0), 32'd0);
        checkOutput("req_cycles", 32'(reqCycles - rq0), 32'(n * (w + 1)));

        foreach (expTx[k]) begin
            if (expTx[k].we) mem[expTx[k].addr[9:2]] = expTx[k].data;
        end
        foreach (expWr[k]) begin
            rf[expWr[k].idx] = expWr[k].data;
        end
    endtask

    initial begin
        int          tx0, wr0;
        logic [15:0] listR;
        logic [31:0] baseR;

        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rf_wdata", rf_write_data, 32'd0);
        checkOutput("rst_rf_waddr", 32'(rf_write_addr), 32'd0);
        checkOutput("rst_rf_raddr", 32'(rf_read_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LDMIA, STMDB, empty list, LDMIB with wait states, base in list.
        applyStimulus(1'b1, 32'h100, 4'd5, 16'h000E, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 32'h200, 4'd13, 16'hC001, 1'b0, 1'b1, 1'b1, 0);
        applyStimulus(1'b0, 32'h400, 4'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 32'h500, 4'd3, 16'h0120, 1'b1, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 32'h600, 4'd4, 16'h0031, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 32'h700, 4'd4, 16'h0031, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 32'h8, 4'd7, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0);

        // Abort during the second of four load beats.
        waitCfg = 2;
        tx0 = txQ.size();
        wr0 = wrQ.size();
        @(negedge clk);
        is_load   = 1'b1;
        up        = 1'b1;
        pre       = 1'b0;
        writeback = 1'b1;
        reg_list  = 16'h00F0;
        base_addr = 32'h300;
        base_reg  = 4'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && txQ.size() == tx0; k++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("rst_first_beat", 32'(txQ.size() - tx0), 32'd1);
        @(posedge clk);
        #3;
        checkOutput("rst_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", 32'(mem_req), 32'd0);
        checkOutput("rst_busy_drop", 32'(busy), 32'd0);
        checkOutput("rst_wr_drop", 32'(rf_wr_en), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_write", 32'(wrQ.size() - wr0), 32'd1);
        checkOutput("rst_no_beat", 32'(txQ.size() - tx0), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_idle", 32'(busy), 32'd0);
        applyStimulus(1'b1, 32'h300, 4'd1, 16'h00F0, 1'b1, 1'b0, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            strayAck = 1'($urandom_range(0, 1));
            listR = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            baseR = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 32)) << 2)
                                                : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(1'($urandom_range(0, 1)), baseR, 4'($urandom_range(0, 15)), listR,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
